// File: rtl/cpu_port_pkg.sv
// Shared register-map offsets and reset values for the CPU I/O port bank.
// Compile with CPU_PORT_IRQ_EN defined to enable the per-port IE register and the change interrupt.
package cpu_port_pkg;

   localparam logic [2:0] PORT_OFF_OUT = 3'd0;
   localparam logic [2:0] PORT_OFF_DIR = 3'd1;
   localparam logic [2:0] PORT_OFF_IN  = 3'd2;
   localparam logic [2:0] PORT_OFF_CHG = 3'd3;
   localparam logic [2:0] PORT_OFF_IE  = 3'd4;

   // Per-bit reset values, replicated to WIDTH at the point of use.
   localparam logic RST_OUT_VAL  = 1'b0;
   localparam logic RST_DIR_VAL  = 1'b0;
   localparam logic RST_SYNC_VAL = 1'b0;
   localparam logic RST_CHG_VAL  = 1'b0;
   localparam logic RST_IE_VAL   = 1'b0;

endpackage

// File: rtl/cpu_port_channel.sv
// One I/O port: OUT/DIR (and IE with CPU_PORT_IRQ_EN) registers, 2-FF input sync, W1C change flags, tristate pins.
// Register writes take effect the edge after the strobe; no backpressure, a write is accepted every cycle.
module cpu_port_channel
   import cpu_port_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_out_i,
   input  logic             wr_dir_i,
   input  logic             wr_chg_i,
`ifdef CPU_PORT_IRQ_EN
   input  logic             wr_ie_i,
   output logic [WIDTH-1:0] ie_o,
`endif
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] out_o,
   output logic [WIDTH-1:0] dir_o,
   output logic [WIDTH-1:0] in_o,
   output logic [WIDTH-1:0] chg_o,
   inout  wire  [WIDTH-1:0] pin_io
);

   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] chg_q, chg_d;
   logic [WIDTH-1:0] s1_q, s2_q, s3_q;

   always_comb begin
      out_d = out_q;
      dir_d = dir_q;
      if (wr_out_i) out_d = wdata_i;
      if (wr_dir_i) dir_d = wdata_i;
      // A fresh edge is OR-ed in after the clear, so it survives a simultaneous W1C.
      chg_d = (chg_q & ~(wr_chg_i ? wdata_i : '0)) | (s2_q ^ s3_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_q <= {WIDTH{RST_OUT_VAL}};
         dir_q <= {WIDTH{RST_DIR_VAL}};
         s1_q  <= {WIDTH{RST_SYNC_VAL}};
         s2_q  <= {WIDTH{RST_SYNC_VAL}};
         s3_q  <= {WIDTH{RST_SYNC_VAL}};
         chg_q <= {WIDTH{RST_CHG_VAL}};
      end else begin
         out_q <= out_d;
         dir_q <= dir_d;
         s1_q  <= pin_io;
         s2_q  <= s1_q;
         s3_q  <= s2_q;
         chg_q <= chg_d;
      end
   end

`ifdef CPU_PORT_IRQ_EN
   logic [WIDTH-1:0] ie_q, ie_d;

   always_comb begin
      ie_d = ie_q;
      if (wr_ie_i) ie_d = wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ie_q <= {WIDTH{RST_IE_VAL}};
      else         ie_q <= ie_d;
   end

   assign ie_o = ie_q;
`endif

   for (genvar b = 0; b < WIDTH; b++) begin : g_pin
      assign pin_io[b] = dir_q[b] ? out_q[b] : 1'bz;
   end

   assign out_o = out_q;
   assign dir_o = dir_q;
   assign in_o  = s2_q;
   assign chg_o = chg_q;

endmodule

// File: rtl/cpu_port_bank.sv
// N_PORTS x WIDTH bidirectional I/O bank on a CPU register bus; read data registered (latency 1), no wait states.
// CPU_PORT_IRQ_EN adds per-port IE and a registered change interrupt; otherwise IRQ is tied low.
module cpu_port_bank
   import cpu_port_pkg::*;
#(
   parameter  int WIDTH   = 8,
   parameter  int N_PORTS = 2,
   localparam int PIDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
   localparam int ADDR_W  = PIDX_W + 3
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic [ADDR_W-1:0]        ADDR,
   input  logic                     WR_EN,
   input  logic                     RD_EN,
   input  logic [WIDTH-1:0]         WDATA,
   output logic [WIDTH-1:0]         RDATA,
   inout  wire  [N_PORTS*WIDTH-1:0] PORT,
   output logic                     IRQ
);

   logic [PIDX_W-1:0] pidx;
   logic [2:0]        off;
   logic [WIDTH-1:0]  out_w [N_PORTS];
   logic [WIDTH-1:0]  dir_w [N_PORTS];
   logic [WIDTH-1:0]  in_w  [N_PORTS];
   logic [WIDTH-1:0]  chg_w [N_PORTS];
`ifdef CPU_PORT_IRQ_EN
   logic [WIDTH-1:0]  ie_w  [N_PORTS];
`endif
   logic [WIDTH-1:0]  rd_val;
   logic [WIDTH-1:0]  rdata_q, rdata_d;

   assign pidx = ADDR[ADDR_W-1:3];
   assign off  = ADDR[2:0];

   // An index with no matching channel selects nothing: writes drop, reads return zero.
   for (genvar p = 0; p < N_PORTS; p++) begin : g_ch
      logic sel;
      assign sel = (pidx == PIDX_W'(p));

      cpu_port_channel #(.WIDTH(WIDTH)) u_ch (
         .clk_i    (CLK),
         .rst_ni   (RST_N),
         .wr_out_i (WR_EN & sel & (off == PORT_OFF_OUT)),
         .wr_dir_i (WR_EN & sel & (off == PORT_OFF_DIR)),
         .wr_chg_i (WR_EN & sel & (off == PORT_OFF_CHG)),
`ifdef CPU_PORT_IRQ_EN
         .wr_ie_i  (WR_EN & sel & (off == PORT_OFF_IE)),
         .ie_o     (ie_w[p]),
`endif
         .wdata_i  (WDATA),
         .out_o    (out_w[p]),
         .dir_o    (dir_w[p]),
         .in_o     (in_w[p]),
         .chg_o    (chg_w[p]),
         .pin_io   (PORT[p*WIDTH +: WIDTH])
      );
   end

   always_comb begin
      rd_val = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         if (pidx == PIDX_W'(p)) begin
            case (off)
               PORT_OFF_OUT: rd_val = out_w[p];
               PORT_OFF_DIR: rd_val = dir_w[p];
               PORT_OFF_IN:  rd_val = in_w[p];
               PORT_OFF_CHG: rd_val = chg_w[p];
`ifdef CPU_PORT_IRQ_EN
               PORT_OFF_IE:  rd_val = ie_w[p];
`endif
               default:      rd_val = '0;
            endcase
         end
      end
   end

   // rd_val is sampled from pre-edge state, so a same-cycle write is not yet visible.
   assign rdata_d = RD_EN ? rd_val : rdata_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) rdata_q <= '0;
      else        rdata_q <= rdata_d;
   end

   assign RDATA = rdata_q;

`ifdef CPU_PORT_IRQ_EN
   logic irq_q, irq_d;

   always_comb begin
      irq_d = 1'b0;
      for (int p = 0; p < N_PORTS; p++) irq_d = irq_d | (|(chg_w[p] & ie_w[p]));
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) irq_q <= 1'b0;
      else        irq_q <= irq_d;
   end

   assign IRQ = irq_q;
`else
   assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_port_bank.sv
// Bench for cpu_port_bank with N_PORTS=3 so that port index 3 is a real out-of-range address.
// Read results are scored through a queue; pin and IRQ values are compared directly at negedges.
module tb_cpu_port_bank;

   localparam int WIDTH   = 8;
   localparam int N_PORTS = 3;
   localparam int ADDR_W  = 5;
`ifdef CPU_PORT_IRQ_EN
   localparam logic [7:0] IE_RB  = 8'h55;
   localparam logic       IRQ_ON = 1'b1;
`else
   localparam logic [7:0] IE_RB  = 8'h00;
   localparam logic       IRQ_ON = 1'b0;
`endif

   logic                     CLK = 1'b0;
   logic                     RST_N;
   logic [ADDR_W-1:0]        ADDR;
   logic                     WR_EN, RD_EN;
   logic [WIDTH-1:0]         WDATA;
   wire  [WIDTH-1:0]         RDATA;
   wire  [N_PORTS*WIDTH-1:0] PORT;
   wire                      IRQ;
   logic [N_PORTS*WIDTH-1:0] tb_en, tb_val;

   for (genvar i = 0; i < N_PORTS*WIDTH; i++) begin : g_drv
      assign PORT[i] = tb_en[i] ? tb_val[i] : 1'bz;
   end

   cpu_port_bank #(.WIDTH(WIDTH), .N_PORTS(N_PORTS)) dut (
      .CLK(CLK), .RST_N(RST_N), .ADDR(ADDR), .WR_EN(WR_EN), .RD_EN(RD_EN),
      .WDATA(WDATA), .RDATA(RDATA), .PORT(PORT), .IRQ(IRQ)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic             wr;
      logic             rd;
      logic [ADDR_W-1:0] addr;
      logic [7:0]       wd;
      logic [7:0]       exp;
   } vec_t;

   typedef struct {
      logic [7:0] exp;
      int         id;
   } sb_t;

   vec_t tbl[$];
   sb_t  sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   tag   = 0;
   bit   chk_now = 1'b0;

   function automatic logic [ADDR_W-1:0] a(input int p, input int o);
      return ADDR_W'((p << 3) | o);
   endfunction

   task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic wr, input logic rd, input logic [ADDR_W-1:0] ad,
                      input logic [7:0] wd, input logic [7:0] ex);
      sb_t e;
      @(negedge CLK);
      WR_EN = wr; RD_EN = rd; ADDR = ad; WDATA = wd;
      if (rd) begin
         e.exp = ex; e.id = tag; tag++;
         sb.push_back(e);
      end
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, '0, 8'h00, 8'h00);
   endtask

   // Scoreboard: a read strobed at a posedge is compared at the following negedge.
   always @(posedge CLK) chk_now = RD_EN & RST_N;

   always @(negedge CLK) begin
      sb_t e;
      if (chk_now) begin
         chk_now = 1'b0;
         if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL rd_unexpected: got %h with empty scoreboard", RDATA);
         end else begin
            e = sb.pop_front();
            check8($sformatf("rd#%0d", e.id), RDATA, e.exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, %0d reads pending", sb.size());
      $fatal(1, "timeout");
   end

   initial begin
      tbl.push_back('{1'b1, 1'b0, a(3,0), 8'hFF, 8'h00});
      tbl.push_back('{1'b1, 1'b0, a(3,1), 8'hFF, 8'h00});
      tbl.push_back('{1'b0, 1'b1, a(3,0), 8'h00, 8'h00});
      tbl.push_back('{1'b0, 1'b1, a(3,1), 8'h00, 8'h00});
      tbl.push_back('{1'b0, 1'b1, a(3,2), 8'h00, 8'h00});
      tbl.push_back('{1'b1, 1'b0, a(0,5), 8'hFF, 8'h00});
      tbl.push_back('{1'b0, 1'b1, a(0,5), 8'h00, 8'h00});
      tbl.push_back('{1'b1, 1'b0, a(1,7), 8'hFF, 8'h00});
      tbl.push_back('{1'b0, 1'b1, a(1,7), 8'h00, 8'h00});
      tbl.push_back('{1'b1, 1'b0, a(1,2), 8'hFF, 8'h00});
      tbl.push_back('{1'b0, 1'b1, a(1,2), 8'h00, 8'hC5});
      tbl.push_back('{1'b1, 1'b1, a(1,0), 8'h5A, 8'hA5});
      tbl.push_back('{1'b0, 1'b1, a(1,0), 8'h00, 8'h5A});
      tbl.push_back('{1'b1, 1'b0, a(2,0), 8'h3C, 8'h00});
      tbl.push_back('{1'b0, 1'b1, a(2,0), 8'h00, 8'h3C});
      tbl.push_back('{1'b0, 1'b1, a(0,0), 8'h00, 8'h00});
      tbl.push_back('{1'b0, 1'b1, a(1,1), 8'h00, 8'h0F});
      tbl.push_back('{1'b1, 1'b0, a(2,4), 8'h55, 8'h00});
      tbl.push_back('{1'b0, 1'b1, a(2,4), 8'h00, IE_RB});
      tbl.push_back('{1'b1, 1'b0, a(2,4), 8'h00, 8'h00});

      RST_N = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0; ADDR = '0; WDATA = '0;
      tb_en = '0; tb_val = '0;
      tb_en[7:0] = 8'hFF;   tb_val[7:0] = 8'h3C;
      tb_en[15:12] = 4'hF;  tb_val[15:12] = 4'hC;
      repeat (2) @(negedge CLK);
      check8("rst_rdata", RDATA, 8'h00);
      check8("rst_irq", {7'b0, IRQ}, 8'h00);
      RST_N = 1'b1;

      // Reset lands in the middle of a DIR write
      @(negedge CLK);
      WR_EN = 1'b1; ADDR = a(0,1); WDATA = 8'hFF;
      #2 RST_N = 1'b0;
      @(negedge CLK);
      WR_EN = 1'b0;
      check8("rst_mid_rdata", RDATA, 8'h00);
      RST_N = 1'b1;
      repeat (3) idle();
      cyc(1'b0, 1'b1, a(0,1), 8'h00, 8'h00);
      cyc(1'b0, 1'b1, a(0,2), 8'h00, 8'h3C);

      // Drive low nibble of port 1; high nibble stays with the bench
      cyc(1'b1, 1'b0, a(1,1), 8'h0F, 8'h00);
      cyc(1'b1, 1'b0, a(1,0), 8'hA5, 8'h00);
      idle();
      check8("pins_p1", PORT[15:8], 8'hC5);
      idle();
      cyc(1'b0, 1'b1, a(1,2), 8'h00, 8'hC5);

      // Input sync latency and change flags
      tb_val[7:0] = 8'h00;
      repeat (4) idle();
      cyc(1'b1, 1'b0, a(0,3), 8'hFF, 8'h00);
      idle();
      cyc(1'b0, 1'b1, a(0,2), 8'h00, 8'h00);
      tb_val[7:0] = 8'h81;
      cyc(1'b0, 1'b1, a(0,2), 8'h00, 8'h00);
      cyc(1'b0, 1'b1, a(0,2), 8'h00, 8'h81);
      cyc(1'b0, 1'b1, a(0,3), 8'h00, 8'h81);
      cyc(1'b1, 1'b0, a(0,3), 8'h01, 8'h00);
      cyc(1'b0, 1'b1, a(0,3), 8'h00, 8'h80);

      // CHG sets exactly on the third edge after a pin change
      cyc(1'b0, 1'b1, a(0,3), 8'h00, 8'h80);
      tb_val[0] = 1'b0;
      cyc(1'b0, 1'b1, a(0,3), 8'h00, 8'h80);
      cyc(1'b0, 1'b1, a(0,3), 8'h00, 8'h80);
      cyc(1'b0, 1'b1, a(0,3), 8'h00, 8'h81);

      // W1C of bit0 on the same edge a new change of bit0 arrives
      idle();
      tb_val[0] = 1'b1;
      idle();
      cyc(1'b1, 1'b0, a(0,3), 8'h01, 8'h00);
      cyc(1'b0, 1'b1, a(0,3), 8'h00, 8'h81);
      cyc(1'b1, 1'b0, a(0,3), 8'h01, 8'h00);
      cyc(1'b0, 1'b1, a(0,3), 8'h00, 8'h80);

      foreach (tbl[i]) cyc(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wd, tbl[i].exp);
      idle();
      check8("pins_p1_after_rw", PORT[15:8], 8'hCA);
      cyc(1'b0, 1'b1, a(1,2), 8'h00, 8'hCA);

      // Change interrupt on pin0 with IE bit0
      cyc(1'b1, 1'b0, a(0,3), 8'hFF, 8'h00);
      cyc(1'b1, 1'b0, a(0,4), 8'h01, 8'h00);
      idle();
      check8("irq_idle", {7'b0, IRQ}, 8'h00);
      idle();
      tb_val[0] = 1'b0;
      idle(); check8("irq_p1", {7'b0, IRQ}, 8'h00);
      idle(); check8("irq_p2", {7'b0, IRQ}, 8'h00);
      idle(); check8("irq_p3", {7'b0, IRQ}, 8'h00);
      cyc(1'b1, 1'b0, a(0,3), 8'h01, 8'h00);
      check8("irq_set", {7'b0, IRQ}, {7'b0, IRQ_ON});
      idle(); check8("irq_hold", {7'b0, IRQ}, {7'b0, IRQ_ON});
      idle(); check8("irq_clear", {7'b0, IRQ}, 8'h00);
      tb_val[1] = ~tb_val[1];
      for (int k = 0; k < 6; k++) begin
         idle();
         check8("irq_masked", {7'b0, IRQ}, 8'h00);
      end

      idle();
      idle();
      for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge CLK);
      if (sb.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL drain: %0d reads still pending, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
